// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the HI/LO
// multiply/divide unit.
package muldiv_pkg;

  localparam logic [4:0] OP_MULT  = 5'd8;
  localparam logic [4:0] OP_MULTU = 5'd9;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MADD  = 5'd17;
  localparam logic [4:0] OP_MSUB  = 5'd18;
  localparam logic [4:0] OP_MFHI  = 5'd21;
  localparam logic [4:0] OP_MTHI  = 5'd22;
  localparam logic [4:0] OP_MFLO  = 5'd23;
  localparam logic [4:0] OP_MTLO  = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  // How the finished product is folded into {HI,LO}.
  typedef enum logic [1:0] {
    MK_MULT,
    MK_MADD,
    MK_MSUB
  } mul_kind_t;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_mf_op(input logic [4:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO unit.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [4:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic [WIDTH-1:0] Result;

  modport master (
    output Start, Op, A, B, Flush,
    input  Busy, Stall, Done, DivByZero, Hi, Lo, Result
  );

  modport slave (
    input  Start, Op, A, B, Flush,
    output Busy, Stall, Done, DivByZero, Hi, Lo, Result
  );
endinterface

// File: rtl/div_iter_core.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH bits total.
// The start edge already resolves the first bit; done pulses once results are valid.
module div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] src_rem, src_quo, src_div;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_next, quo_next;

  // Quotient register doubles as the dividend shift register.
  assign src_rem  = start ? '0 : remainder;
  assign src_quo  = start ? dividend : quotient;
  assign src_div  = start ? divisor : divisor_q;
  assign shifted  = {src_rem, src_quo[WIDTH-1]};
  assign fits     = shifted >= {1'b0, src_div};
  assign rem_next = fits ? WIDTH'(shifted - {1'b0, src_div}) : shifted[WIDTH-1:0];
  assign quo_next = {src_quo[WIDTH-2:0], fits};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      divisor_q <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (clear) begin
      running <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running   <= 1'b1;
        cnt       <= CW'(1);
        divisor_q <= divisor;
        quotient  <= quo_next;
        remainder <= rem_next;
      end else if (running) begin
        quotient  <= quo_next;
        remainder <= rem_next;
        cnt       <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a pipelined multiplier (mult/multu/madd/msub) and an
// iterative divider (div/divu); the pipeline stalls while either is in flight.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input logic               Clk,
  input logic               Reset_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int DW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  mul_kind_t        mul_kind_q;
  logic             a_neg_q, q_neg_q;

  logic             busy, accept, op_mul, op_div, is_div_s, b_zero, mul_signed;
  logic [DW-1:0]    ext_a, ext_b, product, mul_acc;
  logic [DW-1:0]    mul_pipe [MUL_LAT];
  logic [MUL_LAT-1:0] mul_vld;
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quo, div_rem, fix_quo, fix_rem;

  assign busy     = state_q != ST_IDLE;
  assign accept   = bus.Start && !bus.Flush && !busy;
  assign op_mul   = is_mul_op(bus.Op);
  assign op_div   = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
  assign is_div_s = bus.Op == OP_DIV;
  assign b_zero   = bus.B == '0;

  // Extending to 2*WIDTH first makes a truncated 2*WIDTH multiply exact for both signednesses.
  assign mul_signed = bus.Op != OP_MULTU;
  assign ext_a   = mul_signed ? {{WIDTH{bus.A[WIDTH-1]}}, bus.A} : {{WIDTH{1'b0}}, bus.A};
  assign ext_b   = mul_signed ? {{WIDTH{bus.B[WIDTH-1]}}, bus.B} : {{WIDTH{1'b0}}, bus.B};
  assign product = ext_a * ext_b;

  // NOTE: the product pipeline is ordinary flops, so it is reset like any other register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mul_vld <= '0;
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
    end else if (bus.Flush) begin
      mul_vld <= '0;
    end else begin
      mul_vld[0] <= accept && op_mul;
      if (accept && op_mul) mul_pipe[0] <= product;
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_vld[i]  <= mul_vld[i-1];
        mul_pipe[i] <= mul_pipe[i-1];
      end
    end
  end

  always_comb begin
    case (mul_kind_q)
      MK_MADD: mul_acc = {hi_q, lo_q} + mul_pipe[MUL_LAT-1];
      MK_MSUB: mul_acc = {hi_q, lo_q} - mul_pipe[MUL_LAT-1];
      default: mul_acc = mul_pipe[MUL_LAT-1];
    endcase
  end

  // Signed divide runs on magnitudes; the signs are restored in FIX.
  assign div_dividend = (is_div_s && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign div_divisor  = (is_div_s && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  assign div_start    = accept && op_div && !b_zero;

  div_iter_core #(.WIDTH(WIDTH)) u_div (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .clear    (bus.Flush),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign fix_quo = q_neg_q ? -div_quo : div_quo;
  assign fix_rem = a_neg_q ? -div_rem : div_rem;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.Op == OP_MTHI) begin
            hi_d   = bus.A;
            done_d = 1'b1;
          end else if (bus.Op == OP_MTLO) begin
            lo_d   = bus.A;
            done_d = 1'b1;
          end else if (op_mul) begin
            state_d = ST_MUL;
          end else if (op_div) begin
            if (b_zero) begin
              done_d = 1'b1;
              dbz_d  = 1'b1;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
      end
      ST_MUL: begin
        if (bus.Flush) begin
          state_d = ST_IDLE;
        end else if (mul_vld[MUL_LAT-1]) begin
          state_d      = ST_IDLE;
          {hi_d, lo_d} = mul_acc;
          done_d       = 1'b1;
        end
      end
      ST_DIV: begin
        if (bus.Flush)     state_d = ST_IDLE;
        else if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.Flush) begin
          hi_d   = fix_rem;
          lo_d   = fix_quo;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      mul_kind_q <= MK_MULT;
      a_neg_q    <= 1'b0;
      q_neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      if (accept) begin
        mul_kind_q <= (bus.Op == OP_MADD) ? MK_MADD :
                      (bus.Op == OP_MSUB) ? MK_MSUB : MK_MULT;
        a_neg_q    <= is_div_s && bus.A[WIDTH-1];
        q_neg_q    <= is_div_s && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      end
    end
  end

  // mfhi/mflo keep stalling through the Done cycle of the op they wait on.
  assign bus.Stall     = bus.Start && (busy || (done_q && is_mf_op(bus.Op)));
  assign bus.Busy      = busy;
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.Result    = (bus.Op == OP_MFHI) ? hi_q :
                         (bus.Op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomised self-checking bench for hilo_muldiv_unit with an arithmetic
// reference model of HI/LO and of the latency of each op.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_unit #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference: HI/LO contents after the op, cycles from Start to Done, DivByZero flag.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit dbz);
    longint sa, sb, ua, ub;
    logic [63:0] prod, acc;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    lat = 1;
    dbz = 1'b0;
    acc = {hi_m, lo_m};
    case (op)
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      OP_MULT, OP_MADD, OP_MSUB, OP_MULTU: begin
        prod = (op == OP_MULTU) ? 64'(ua * ub) : 64'(sa * sb);
        if (op == OP_MADD)      acc = acc + prod;
        else if (op == OP_MSUB) acc = acc - prod;
        else                    acc = prod;
        {hi_m, lo_m} = acc;
        lat = MUL_LAT + 1;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          dbz = 1'b1;
        end else begin
          lo_m = (op == OP_DIV) ? 32'(sa / sb) : 32'(ua / ub);
          hi_m = (op == OP_DIV) ? 32'(sa % sb) : 32'(ua % ub);
          lat = WIDTH + 2;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    bit dbz;
    int cyc;
    model(op, a, b, lat, dbz);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.Start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    cyc = 1;
    while (bus.Done !== 1'b1 && cyc < 200) begin
      check({tag, "_busy"}, 64'(bus.Busy), 64'd1);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_at_done"}, 64'(bus.Busy), 64'd0);
    check({tag, "_dbz"}, 64'(bus.DivByZero), 64'(dbz));
    check({tag, "_hi"}, 64'(bus.Hi), 64'(hi_m));
    check({tag, "_lo"}, 64'(bus.Lo), 64'(lo_m));
    tick();
    check({tag, "_done_pulse"}, 64'(bus.Done), 64'd0);
  endtask

  logic [4:0] ops [8] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

  initial begin
    int cyc;
    int n_done;
    logic [31:0] a, b;
    logic [4:0]  op;

    bus.Start = 1'b0;
    bus.Op    = '0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Flush = 1'b0;
    repeat (2) tick();
    check("rst_hi", 64'(bus.Hi), 64'd0);
    check("rst_lo", 64'(bus.Lo), 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_dbz", 64'(bus.DivByZero), 64'd0);
    Reset_n = 1'b1;
    tick();

    // Multiply, signed and unsigned
    run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_hi_const", 64'(bus.Hi), 64'hFFFF_FFFF);
    check("mult_lo_const", 64'(bus.Lo), 64'hFFFF_FFEB);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFD, 32'd7);
    check("multu_hi_const", 64'(bus.Hi), 64'h6);

    // Divide including overflow corner
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", 64'(bus.Lo), 64'hFFFF_FFFD);
    run_op("divu", OP_DIVU, 32'd7, 32'd2);
    check("divu_hi_const", 64'(bus.Hi), 64'd1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", 64'(bus.Lo), 64'h8000_0000);

    // Divide by zero leaves HI/LO alone
    run_op("mthi11", OP_MTHI, 32'h11, 32'd0);
    run_op("mtlo22", OP_MTLO, 32'h22, 32'd0);
    run_op("div0", OP_DIV, 32'd5, 32'd0);
    check("div0_hi_const", 64'(bus.Hi), 64'h11);

    // Accumulate with wrap
    run_op("mthi0", OP_MTHI, 32'd0, 32'd0);
    run_op("mtlo_ff", OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    run_op("madd", OP_MADD, 32'd1, 32'd1);
    check("madd_hi_const", 64'(bus.Hi), 64'd1);
    run_op("msub", OP_MSUB, 32'd1, 32'd1);
    run_op("mtlo0", OP_MTLO, 32'd0, 32'd0);
    run_op("mthi0b", OP_MTHI, 32'd0, 32'd0);
    run_op("msub_wrap", OP_MSUB, 32'd1, 32'd1);
    check("msub_wrap_const", 64'(bus.Hi), 64'hFFFF_FFFF);

    // mflo held behind a divide
    model(OP_DIV, 32'd100, 32'd7, cyc, b[0]);
    bus.Start = 1'b1;
    bus.Op    = OP_DIV;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    tick();
    bus.Op = OP_MFLO;
    cyc = 1;
    while (bus.Done !== 1'b1 && cyc < 200) begin
      check("mflo_stall_busy", 64'(bus.Stall), 64'd1);
      tick();
      cyc++;
    end
    check("mflo_latency", 64'(cyc), 64'(WIDTH + 2));
    check("mflo_stall_done", 64'(bus.Stall), 64'd1);
    tick();
    check("mflo_stall_after", 64'(bus.Stall), 64'd0);
    check("mflo_result", 64'(bus.Result), 64'd14);
    check("mflo_hi", 64'(bus.Hi), 64'd2);
    bus.Op = OP_MFHI;
    #1;
    check("mfhi_result", 64'(bus.Result), 64'(hi_m));
    bus.Start = 1'b0;
    tick();

    // Undefined ops are ignored
    bus.Start = 1'b1;
    bus.Op    = 5'd3;
    tick();
    bus.Start = 1'b0;
    check("undef_busy", 64'(bus.Busy), 64'd0);
    check("undef_done", 64'(bus.Done), 64'd0);
    check("undef_result", 64'(bus.Result), 64'd0);

    // Flush in the Start cycle cancels the op
    bus.Start = 1'b1;
    bus.Flush = 1'b1;
    bus.Op    = OP_MTHI;
    bus.A     = 32'hDEAD_BEEF;
    tick();
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    check("flush_start_done", 64'(bus.Done), 64'd0);
    check("flush_start_hi", 64'(bus.Hi), 64'(hi_m));

    // Flush coinciding with the multiply write edge
    bus.Start = 1'b1;
    bus.Op    = OP_MULT;
    bus.A     = 32'd9;
    bus.B     = 32'd9;
    tick();
    bus.Start = 1'b0;
    tick();
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    check("flush_mul_done", 64'(bus.Done), 64'd0);
    check("flush_mul_busy", 64'(bus.Busy), 64'd0);
    check("flush_mul_lo", 64'(bus.Lo), 64'(lo_m));

    // Flush mid-divide
    run_op("mthi_f", OP_MTHI, 32'h1234, 32'd0);
    run_op("mtlo_f", OP_MTLO, 32'h5678, 32'd0);
    bus.Start = 1'b1;
    bus.Op    = OP_DIVU;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    tick();
    bus.Start = 1'b0;
    repeat (9) tick();
    check("flush_div_busy_before", 64'(bus.Busy), 64'd1);
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    check("flush_div_busy", 64'(bus.Busy), 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done === 1'b1) n_done++;
      tick();
    end
    check("flush_div_no_done", 64'(n_done), 64'd0);
    check("flush_div_hi", 64'(bus.Hi), 64'(hi_m));
    check("flush_div_lo", 64'(bus.Lo), 64'(lo_m));

    // Asynchronous reset mid-divide
    bus.Start = 1'b1;
    bus.Op    = OP_DIVU;
    bus.A     = 32'd77;
    bus.B     = 32'd5;
    tick();
    bus.Start = 1'b0;
    repeat (4) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    hi_m = '0;
    lo_m = '0;
    check("arst_hi", 64'(bus.Hi), 64'd0);
    check("arst_lo", 64'(bus.Lo), 64'd0);
    check("arst_busy", 64'(bus.Busy), 64'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS datapath. It executes mult, multu, madd, msub, div, divu, mthi, mtlo, mfhi and mflo, selected by the 5-bit ALU control code. The unit sits beside the ALU in EX and stalls the pipeline while an iterative operation is in flight. Operand width and multiply latency are parametrised.

Parameters:
WIDTH, 32, operand/HI/LO width (>=4, even)
MUL_LAT, 2, cycles from Start edge to HI/LO update for the multiply family (>=1)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous reset, active-low
Start  in  1  op request valid this cycle
Op  in  5  ALU control code: 8 mult, 9 multu, 15 div, 16 divu, 17 madd, 18 msub, 21 mfhi, 22 mthi, 23 mflo, 24 mtlo
A  in  WIDTH  rs operand / dividend
B  in  WIDTH  rt operand / divisor
Flush  in  1  cancel in-flight op
Busy  out  1  op in flight
Stall  out  1  Start && Busy (combinational); pipeline must hold
Done  out  1  one-cycle pulse when HI/LO are written
DivByZero  out  1  pulses with Done when a div/divu had B==0
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register
Result  out  WIDTH  combinational: Hi if Op==21, Lo if Op==23, else 0

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Hi, Lo, Busy, Done, DivByZero = 0; divider and multiply pipeline cleared. Reset mid-operation aborts it with no Done.
- Start is accepted only in IDLE; while Busy, Start is ignored and Stall=1.
- States: IDLE, MUL, DIV, FIX.
- mthi/mtlo: Hi/Lo <= A at the Start edge; Done=1 the following cycle; Busy stays 0.
- mfhi/mflo: no state change, no Done. When Busy, Stall=1 until the cycle after Done.
- mult/multu/madd/msub: IDLE->MUL at the Start edge, Busy=1. The 2*WIDTH product is signed for mult/madd/msub and unsigned for multu. At edge t0+MUL_LAT:
  - mult/multu: {Hi,Lo} <= product
  - madd: {Hi,Lo} += product
  - msub: {Hi,Lo} -= product
  - Accumulation is modulo 2^(2*WIDTH).
  - Done=1 and Busy=0 in the cycle after that edge; state returns to IDLE.
- div/divu:
  - IDLE->DIV at the Start edge. Operands are captured, and for div their absolute values are taken.
  - Restoring divide runs one quotient bit per cycle for WIDTH cycles, then FIX for 1 cycle (sign correction), then Hi/Lo are written.
  - Total latency: WIDTH+1 edges after Start; Done follows.
  - Lo = quotient, truncated toward zero. Hi = remainder, with the sign of the dividend.
  - div of most-negative by -1: Lo = most-negative, Hi = 0. No trap.
- Divide by zero: no iteration. Hi/Lo unchanged. Done and DivByZero pulse in the cycle after Start.
- Flush: in any non-IDLE state, return to IDLE at the next edge. Hi/Lo unchanged, no Done. Flush in the Start cycle cancels that op. Flush in the same cycle as the final write edge: Flush wins, no write.
- Undefined Op with Start: ignored, no Done, no Busy.
- Operands are registered at Start; A/B may change during Busy without effect.

Decomposition:
- Package muldiv_pkg holds:
  - localparam op codes: OP_MULT=8, OP_MULTU=9, OP_DIV=15, OP_DIVU=16, OP_MADD=17, OP_MSUB=18, OP_MFHI=21, OP_MTHI=22, OP_MFLO=23, OP_MTLO=24
  - state encoding for IDLE/MUL/DIV/FIX
- One sub-module: div_iter_core (WIDTH). Unsigned restoring divider with start/done, a WIDTH-cycle iteration counter and a synchronous clear for Flush.
- Multiply is an inline MUL_LAT-deep register pipeline.

Test Plan:
1. WIDTH=32, MUL_LAT=2: mult A=0xFFFFFFFD, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy for 2 cycles; Done 1 cycle. multu with the same operands -> Hi=0x00000006, Lo=0xFFFFFFEB.
2. div A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; Done exactly 34 cycles after Start. divu A=7, B=2 -> Lo=3, Hi=1. div 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
3. div A=5, B=0 with Hi=0x11, Lo=0x22 -> Done and DivByZero pulse the next cycle; Hi=0x11, Lo=0x22.
4. mthi 0, mtlo 0xFFFFFFFF, madd 1*1 -> Hi=1, Lo=0. msub 1*1 -> Hi=0, Lo=0xFFFFFFFF. msub 1*1 on Hi=Lo=0 -> Hi=Lo=0xFFFFFFFF (wrap).
5. Start div 100/7, then hold Start with mflo from the next cycle -> Stall=1 through the Done cycle; Result=14 once Stall drops; Hi=2.
6. Start divu, Flush at cycle 10 -> no Done, Hi/Lo unchanged, Busy=0 next cycle. Start divu, Reset_n=0 at cycle 5 -> Hi=Lo=0, Busy=0 immediately.
